// File: rtl/led_step_timer_if.sv
// Signal bundle between the LED step timer and its board-side user:
// pushbutton pins, direction/mode controls, and count/LED/status outputs.
interface led_step_timer_if #(
  parameter int CW   = 4,
  parameter int NLED = 10
);
  logic            btn_run_n;
  logic            btn_clr_n;
  logic            dir;
  logic [1:0]      mode;
  logic [CW-1:0]   count;
  logic [NLED-1:0] led;
  logic            running;
  logic            tick;
  logic            tc;

  // Board/user side: drives buttons and controls, observes the timer.
  modport master (
    output btn_run_n, btn_clr_n, dir, mode,
    input  count, led, running, tick, tc
  );

  // Timer side.
  modport slave (
    input  btn_run_n, btn_clr_n, dir, mode,
    output count, led, running, tick, tc
  );
endinterface

// File: rtl/led_step_timer.sv
// Run/stop step timer for the LED bank: two-stage prescaler, modulo-N
// up/down counter, registered LED rendering in four display modes, and
// synchronised pushbutton start/stop and clear.
//
// Run-control FSM:
//   state   | meaning
//   ST_STOP | prescalers and count frozen, tick suppressed
//   ST_RUN  | prescalers advancing, count steps on each step pulse
module led_step_timer #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int STEP_TICKS = 1000,
  parameter int MODULUS    = 10,
  parameter int NLED       = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  led_step_timer_if.slave bus
);

  localparam int DIV1 = CLK_HZ / TICK_HZ;
  localparam int CW   = $clog2(MODULUS);
  localparam int W1   = $clog2(DIV1);
  localparam int W2   = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  localparam logic [W1-1:0] PRE1_LAST  = W1'(DIV1 - 1);
  localparam logic [W2-1:0] PRE2_LAST  = W2'(STEP_TICKS - 1);
  localparam logic [CW-1:0] COUNT_LAST = CW'(MODULUS - 1);

  if (CLK_HZ % TICK_HZ != 0) begin : g_chk_div
    $error("CLK_HZ must be an integer multiple of TICK_HZ");
  end
  if (DIV1 < 2) begin : g_chk_div1
    $error("CLK_HZ/TICK_HZ must be at least 2");
  end
  if (STEP_TICKS < 1) begin : g_chk_step
    $error("STEP_TICKS must be at least 1");
  end
  if (MODULUS < 2) begin : g_chk_mod
    $error("MODULUS must be at least 2");
  end
  if (NLED < MODULUS) begin : g_chk_nled
    $error("NLED must be at least MODULUS");
  end

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  run_state_t state_q, state_d;

  // bit 0: first sync stage, bit 1: second sync stage, bit 2: history
  logic [2:0] run_sync_q;
  logic [2:0] clr_sync_q;
  logic       run_press;
  logic       clr_press;

  logic [W1-1:0]   pre1_q;
  logic [W2-1:0]   pre2_q;
  logic [CW-1:0]   count_q;
  logic [NLED-1:0] led_q;
  logic [NLED-1:0] led_d;

  logic running;
  logic tick;
  logic step;
  logic wrap;
  logic tc;

  // Button synchronisers and falling-edge history; released level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sync_q <= 3'b111;
      clr_sync_q <= 3'b111;
    end else begin
      run_sync_q <= {run_sync_q[1], run_sync_q[0], bus.btn_run_n};
      clr_sync_q <= {clr_sync_q[1], clr_sync_q[0], bus.btn_clr_n};
    end
  end

  assign run_press = run_sync_q[2] & ~run_sync_q[1];
  assign clr_press = clr_sync_q[2] & ~clr_sync_q[1];

  // Run-control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_STOP;
    else        state_q <= state_d;
  end

  // Run-control next state: each run press toggles run/stop.
  always_comb begin
    state_d = state_q;
    running = (state_q == ST_RUN);
    if (run_press) begin
      state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  // Tick/step/terminal-count decode from registered state; a clear in the
  // same cycle cancels the step, so no tc is reported for it.
  always_comb begin
    tick = running && (pre1_q == PRE1_LAST);
    step = tick && (pre2_q == PRE2_LAST);
    wrap = bus.dir ? (count_q == '0) : (count_q == COUNT_LAST);
    tc   = step && wrap && !clr_press;
  end

  // Prescalers and count; stopping freezes everything so a resume
  // continues the partial step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre1_q  <= '0;
      pre2_q  <= '0;
      count_q <= '0;
    end else if (clr_press) begin
      pre1_q  <= '0;
      pre2_q  <= '0;
      count_q <= '0;
    end else if (running) begin
      pre1_q <= tick ? '0 : pre1_q + 1'b1;
      if (tick) begin
        pre2_q <= (pre2_q == PRE2_LAST) ? '0 : pre2_q + 1'b1;
      end
      if (step) begin
        if (bus.dir) count_q <= (count_q == '0) ? COUNT_LAST : count_q - 1'b1;
        else         count_q <= (count_q == COUNT_LAST) ? '0 : count_q + 1'b1;
      end
    end
  end

  // LED rendering of the current count; positions beyond the count range
  // stay dark in the bar-style modes.
  always_comb begin
    led_d = '0;
    case (bus.mode)
      2'b00: begin
        for (int i = 0; i < NLED; i++) begin
          if (i < MODULUS) led_d[i] = (CW'(i) == count_q);
        end
      end
      2'b01: begin
        for (int i = 0; i < NLED; i++) begin
          if (i < MODULUS) led_d[i] = (CW'(i) <= count_q);
        end
      end
      2'b10:   led_d = NLED'(count_q);
      default: led_d = '0;
    endcase
  end

  // Registered LED drive, one cycle behind the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign bus.count   = count_q;
  assign bus.led     = led_q;
  assign bus.running = running;
  assign bus.tick    = tick;
  assign bus.tc      = tc;

endmodule

// File: tb/tb_led_step_timer.sv
// Directed bench for led_step_timer with DIV1=10, STEP_TICKS=5 (a step
// every 50 running cycles), MODULUS=4 and a 6-LED bank.
module tb_led_step_timer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   tick_cnt;
  int   tc_cnt;
  int   tick_base;

  led_step_timer_if #(.CW(2), .NLED(6)) bus ();

  led_step_timer #(
    .CLK_HZ(100), .TICK_HZ(10), .STEP_TICKS(5), .MODULUS(4), .NLED(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for tick and tc, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tick) tick_cnt <= tick_cnt + 1;
      if (bus.tc)   tc_cnt   <= tc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Holds the run button low across the synchroniser; returns on the
  // negedge just after the edge where running toggles.
  task automatic press_run();
    bus.btn_run_n = 1'b0;
    repeat (3) @(negedge clk);
    bus.btn_run_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; tick_cnt = 0; tc_cnt = 0; tick_base = 0;
    bus.btn_run_n = 1'b1;
    bus.btn_clr_n = 1'b1;
    bus.dir       = 1'b0;
    bus.mode      = 2'b00;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;
    #4;
    chk("rst_count",   bus.count,   0);
    chk("rst_running", bus.running, 0);
    chk("rst_tick",    bus.tick,    0);
    chk("rst_tc",      bus.tc,      0);
    chk("rst_led",     bus.led,     0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("led_after_reset", bus.led, 6'b000001);

    // idle
    repeat (199) @(negedge clk);
    chk("idle_count",   bus.count,   0);
    chk("idle_running", bus.running, 0);
    chk("idle_led",     bus.led,     6'b000001);
    #1 chk("idle_no_tick", tick_cnt, 0);

    // run up through one wrap
    @(negedge clk);
    press_run();
    chk("run_started", bus.running, 1);
    for (int k = 1; k <= 5; k++) begin
      repeat ((k == 1) ? 49 : 48) @(negedge clk);
      chk("up_pre_tick", bus.tick, 1);
      chk("up_pre_tc",   bus.tc,   (k == 4) ? 1 : 0);
      @(negedge clk);
      chk("up_count",   bus.count, k % 4);
      chk("up_led_lag", bus.led,   32'(6'b000001 << ((k - 1) % 4)));
      @(negedge clk);
      chk("up_led",     bus.led,   32'(6'b000001 << (k % 4)));
    end
    #1 chk("up_tc_pulses", tc_cnt, 1);

    // stop mid-step at pre1=5, then resume
    repeat (4) @(negedge clk);
    press_run();
    chk("stop_running", bus.running, 0);
    chk("stop_count",   bus.count,   1);
    #1 tick_base = tick_cnt;
    repeat (100) @(negedge clk);
    chk("stopped_count", bus.count, 1);
    #1 chk("stopped_no_tick", tick_cnt, tick_base);
    @(negedge clk);
    press_run();
    chk("resume_running", bus.running, 1);
    repeat (41) @(negedge clk);
    chk("resume_pre_tick",  bus.tick,  1);
    chk("resume_pre_count", bus.count, 1);
    @(negedge clk);
    chk("resume_step", bus.count, 2);

    // count down 2 -> 1 -> 0 -> 3
    bus.dir = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      repeat (49) @(negedge clk);
      chk("dn_pre_tc", bus.tc, (j == 3) ? 1 : 0);
      @(negedge clk);
      chk("dn_count", bus.count, (6 - j) % 4);
    end
    #1 chk("dn_tc_pulses", tc_cnt, 2);

    // display modes at count=3
    bus.mode = 2'b01;
    @(negedge clk);
    chk("led_thermo", bus.led, 6'b001111);
    bus.mode = 2'b10;
    @(negedge clk);
    chk("led_binary", bus.led, 6'b000011);
    bus.mode = 2'b11;
    @(negedge clk);
    chk("led_blank", bus.led, 6'b000000);
    bus.mode = 2'b00;
    @(negedge clk);
    chk("led_onehot", bus.led, 6'b001000);

    // clear coinciding with the 3 -> 0 wrap step
    bus.dir = 1'b0;
    repeat (43) @(negedge clk);
    bus.btn_clr_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_step_tick", bus.tick,  1);
    chk("clr_step_tc",   bus.tc,    0);
    chk("clr_pre_count", bus.count, 3);
    @(negedge clk);
    bus.btn_clr_n = 1'b1;
    chk("clr_count",   bus.count,   0);
    chk("clr_running", bus.running, 1);
    repeat (49) @(negedge clk);
    chk("clr_next_tick",  bus.tick,  1);
    chk("clr_next_tc",    bus.tc,    0);
    chk("clr_next_pre",   bus.count, 0);
    @(negedge clk);
    chk("clr_next_count", bus.count, 1);
    #1 chk("clr_tc_pulses", tc_cnt, 2);

    // asynchronous reset while running at count=2
    repeat (50) @(negedge clk);
    chk("pre_rst_count", bus.count, 2);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("arst_count",   bus.count,   0);
    chk("arst_running", bus.running, 0);
    chk("arst_tick",    bus.tick,    0);
    chk("arst_tc",      bus.tc,      0);
    chk("arst_led",     bus.led,     0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 tick_base = tick_cnt;
    repeat (60) @(negedge clk);
    chk("post_rst_running", bus.running, 0);
    chk("post_rst_count",   bus.count,   0);
    chk("post_rst_led",     bus.led,     6'b000001);
    #1 chk("post_rst_no_tick", tick_cnt, tick_base);
    chk("post_rst_tc_pulses", tc_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
